jtag_tap_multichain: RTL

Complete single-clock JTAG TAP: 16-state IEEE 1149.1 controller, parametrised instruction register, BYPASS and IDCODE registers, and NUM_CHAINS user data chains, each with its own scan and shadow stage. It is the successor to the standalone scan/IR/bypass blocks and sits between the chip's JTAG pins and user debug/config logic. TDO is muxed from the register selected by the current instruction.

---
 rtl/jtag_tap_multichain_pkg.sv | 36 +++
 rtl/jtag_tap_multichain_chain.sv | 53 +++++
 rtl/jtag_tap_multichain.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jtag_tap_multichain_pkg.sv
// Shared TAP definitions: 4-bit 1149.1 state encodings, opcode constants and
// the opcode-to-user-chain decode used by the multichain TAP.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } tap_state_e;

  localparam int unsigned IDCODE_OP = 1;
  localparam int unsigned BYPASS_OP = 32'hFFFF_FFFF;
  localparam int unsigned USER_BASE = 2;

  // Returns the user chain index an opcode selects, or -1 when it selects none.
  function automatic int op_to_chain(input int unsigned op, input int unsigned num_chains);
    if (op >= USER_BASE && (op - USER_BASE) < num_chains) begin
      return int'(op - USER_BASE);
    end
    return -1;
  endfunction

endpackage

// File: rtl/jtag_tap_multichain_chain.sv
// Generic TAP scan register: shift stage with capture/shift enables plus a
// shadow stage loaded on update, used for the IR and every user data chain.
module tap_data_chain
  import jtag_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             update_i,
  input  logic             load_reset_i,
  input  logic [WIDTH-1:0] capture_data_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  output logic [WIDTH-1:0] shadow_o
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shadow_q;

  // Right shift with tdi entering at the MSB; written this way so WIDTH=1 works.
  always_comb begin
    shift_d = shift_q >> 1;
    shift_d[WIDTH-1] = tdi_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
    end else if (capture_i) begin
      shift_q <= capture_data_i;
    end else if (shift_i) begin
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= RESET_VAL;
    end else if (load_reset_i) begin
      shadow_q <= RESET_VAL;
    end else if (update_i) begin
      shadow_q <= shift_q;
    end
  end

  assign tdo_o    = shift_q[0];
  assign shadow_o = shadow_q;

endmodule

// File: rtl/jtag_tap_multichain.sv
// JTAG TAP with IR, BYPASS, optional IDCODE and NUM_CHAINS user data chains.
// Define JTAG_IDCODE_EN to include the IDCODE register (reset opcode IDCODE).
module jtag_tap_multichain
  import jtag_pkg::*;
#(
  parameter int                   IR_WIDTH     = 4,
  parameter int                   DR_WIDTH     = 8,
  parameter int                   NUM_CHAINS   = 2,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001,
  parameter logic [DR_WIDTH-1:0]  DR_RESET     = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tms,
  input  logic                           tdi,
  output logic                           tdo,
  output logic                           tdo_en,
  input  logic [NUM_CHAINS*DR_WIDTH-1:0] dr_capture_data,
  output logic [NUM_CHAINS*DR_WIDTH-1:0] dr_update_data,
  output logic [NUM_CHAINS-1:0]          update_strobe,
  output logic [IR_WIDTH-1:0]            instruction,
  output logic [3:0]                     tap_state
);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OP = IR_WIDTH'(IDCODE_OP);
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP = IR_WIDTH'(BYPASS_OP);
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e state_q;
  logic       capture_dr, shift_dr, update_dr;
  logic       shift_ir, ir_tdo, dr_tdo;
  logic       sel_idcode, sel_bypass;
  int         sel_chain;
  logic       bypass_q;
  logic [NUM_CHAINS-1:0] chain_tdo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      case (state_q)
        TEST_LOGIC_RESET: state_q <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_q <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state_q <= tms ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state_q <= tms ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state_q <= tms ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state_q <= tms ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state_q <= tms ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state_q <= tms ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state_q <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state_q <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_q <= tms ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state_q <= tms ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state_q <= tms ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state_q <= tms ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state_q <= tms ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state_q <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state_q <= TEST_LOGIC_RESET;
      endcase
    end
  end

  assign capture_dr = (state_q == CAPTURE_DR);
  assign shift_dr   = (state_q == SHIFT_DR);
  assign update_dr  = (state_q == UPDATE_DR);
  assign shift_ir   = (state_q == SHIFT_IR);
  assign tap_state  = state_q;
  assign tdo_en     = shift_ir | shift_dr;

  tap_data_chain #(.WIDTH(IR_WIDTH), .RESET_VAL(RESET_OP)) u_ir (
    .clk            (clk),
    .reset          (reset),
    .capture_i      (state_q == CAPTURE_IR),
    .shift_i        (shift_ir),
    .update_i       (state_q == UPDATE_IR),
    .load_reset_i   (state_q == TEST_LOGIC_RESET),
    .capture_data_i (IR_CAPTURE),
    .tdi_i          (tdi),
    .tdo_o          (ir_tdo),
    .shadow_o       (instruction)
  );

  // Any opcode that is neither IDCODE nor a valid USER code falls back to BYPASS.
  assign sel_chain = op_to_chain(32'(instruction), unsigned'(NUM_CHAINS));
`ifdef JTAG_IDCODE_EN
  assign sel_idcode = (instruction == IR_WIDTH'(IDCODE_OP));
`else
  assign sel_idcode = 1'b0;
`endif
  assign sel_bypass = !sel_idcode && (sel_chain < 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bypass_q <= 1'b0;
    end else if (capture_dr && sel_bypass) begin
      bypass_q <= 1'b0;
    end else if (shift_dr && sel_bypass) begin
      bypass_q <= tdi;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idcode_q <= '0;
    end else if (capture_dr && sel_idcode) begin
      idcode_q <= IDCODE_VALUE;
    end else if (shift_dr && sel_idcode) begin
      idcode_q <= {tdi, idcode_q[31:1]};
    end
  end
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain
    tap_data_chain #(.WIDTH(DR_WIDTH), .RESET_VAL(DR_RESET)) u_chain (
      .clk            (clk),
      .reset          (reset),
      .capture_i      (capture_dr && (sel_chain == k)),
      .shift_i        (shift_dr && (sel_chain == k)),
      .update_i       (update_dr && (sel_chain == k)),
      .load_reset_i   (1'b0),
      .capture_data_i (dr_capture_data[k*DR_WIDTH +: DR_WIDTH]),
      .tdi_i          (tdi),
      .tdo_o          (chain_tdo[k]),
      .shadow_o       (dr_update_data[k*DR_WIDTH +: DR_WIDTH])
    );
    assign update_strobe[k] = update_dr && (sel_chain == k);
  end

  always_comb begin
    dr_tdo = bypass_q;
`ifdef JTAG_IDCODE_EN
    if (sel_idcode) dr_tdo = idcode_q[0];
`endif
    for (int k = 0; k < NUM_CHAINS; k++) begin
      if (sel_chain == k) dr_tdo = chain_tdo[k];
    end
  end

  assign tdo = shift_ir ? ir_tdo : (shift_dr ? dr_tdo : 1'b0);

endmodule
